// File: rtl/id_branch_unit.sv
// ID-stage branch/jump resolver: operand forwarding, condition evaluation, a BHT of
// saturating counters, a registered redirect with wrong-path squash, and statistics counters.
module id_branch_unit #(
  parameter int BUS_WIDTH        = 64,
  parameter int BHT_DEPTH        = 64,
  parameter int CTR_WIDTH        = 2,
  parameter int FWD_SOURCES      = 3,
  parameter int BRANCH_SRC_WIDTH = 3,
  parameter int STAT_WIDTH       = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [BUS_WIDTH-1:0]               if_pc,
  output logic                               if_predict_taken,
  input  logic                               valid_in,
  input  logic                               stall,
  input  logic [BUS_WIDTH-1:0]               pc,
  input  logic [BUS_WIDTH-1:0]               imm,
  input  logic                               pred_in,
  input  logic                               jump_src,
  input  logic                               jalr_src,
  input  logic [BRANCH_SRC_WIDTH-1:0]        branch_src,
  input  logic [BUS_WIDTH-1:0]               read_data1,
  input  logic [BUS_WIDTH-1:0]               read_data2,
  input  logic [FWD_SOURCES-1:0]             fwd_sel_a,
  input  logic [FWD_SOURCES-1:0]             fwd_sel_b,
  input  logic [FWD_SOURCES*BUS_WIDTH-1:0]   fwd_vals,
  output logic                               redirect_valid,
  output logic [BUS_WIDTH-1:0]               redirect_pc,
  output logic                               branch_taken,
  output logic [STAT_WIDTH-1:0]              branch_count,
  output logic [STAT_WIDTH-1:0]              mispredict_count
);

  localparam int IDX = $clog2(BHT_DEPTH);
  localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);
  localparam logic [CTR_WIDTH-1:0] CTR_MAX  = '1;
  localparam logic [CTR_WIDTH-1:0] CTR_MIN  = '0;

  localparam logic [BRANCH_SRC_WIDTH-1:0] BR_NONE = BRANCH_SRC_WIDTH'(0);
  localparam logic [BRANCH_SRC_WIDTH-1:0] BR_BEQ  = BRANCH_SRC_WIDTH'(1);
  localparam logic [BRANCH_SRC_WIDTH-1:0] BR_BNE  = BRANCH_SRC_WIDTH'(2);
  localparam logic [BRANCH_SRC_WIDTH-1:0] BR_BLT  = BRANCH_SRC_WIDTH'(3);
  localparam logic [BRANCH_SRC_WIDTH-1:0] BR_BGE  = BRANCH_SRC_WIDTH'(4);
  localparam logic [BRANCH_SRC_WIDTH-1:0] BR_BLTU = BRANCH_SRC_WIDTH'(5);
  localparam logic [BRANCH_SRC_WIDTH-1:0] BR_BGEU = BRANCH_SRC_WIDTH'(6);

  logic [CTR_WIDTH-1:0] bht [BHT_DEPTH];
  logic                 squash;
  logic [BUS_WIDTH-1:0] op_a;
  logic [BUS_WIDTH-1:0] op_b;
  logic                 act;
  logic                 is_jump;
  logic                 is_branch;
  logic                 cond_true;
  logic                 mispredict;
  logic                 redirect_next;
  logic [BUS_WIDTH-1:0] target_pc;
  logic [BUS_WIDTH-1:0] seq_pc;
  logic [BUS_WIDTH-1:0] jalr_sum;
  logic [BUS_WIDTH-1:0] next_pc;
  logic [IDX-1:0]       id_idx;
  logic [IDX-1:0]       if_idx;
  logic                 unused_bits;

  // Iterating from the oldest source down makes the lowest set enable win.
  always_comb begin
    op_a = read_data1;
    op_b = read_data2;
    for (int k = FWD_SOURCES - 1; k >= 0; k--) begin
      if (fwd_sel_a[k]) op_a = fwd_vals[k*BUS_WIDTH +: BUS_WIDTH];
      if (fwd_sel_b[k]) op_b = fwd_vals[k*BUS_WIDTH +: BUS_WIDTH];
    end
  end

  assign act     = valid_in & ~stall & ~squash;
  assign is_jump = jump_src;

  always_comb begin
    cond_true = 1'b0;
    is_branch = ~jump_src;
    case (branch_src)
      BR_BEQ:  cond_true = (op_a == op_b);
      BR_BNE:  cond_true = (op_a != op_b);
      BR_BLT:  cond_true = ($signed(op_a) <  $signed(op_b));
      BR_BGE:  cond_true = ($signed(op_a) >= $signed(op_b));
      BR_BLTU: cond_true = (op_a <  op_b);
      BR_BGEU: cond_true = (op_a >= op_b);
      BR_NONE: is_branch = 1'b0;
      default: is_branch = 1'b0;
    endcase
  end

  assign target_pc = pc + imm;
  assign seq_pc    = pc + BUS_WIDTH'(4);
  assign jalr_sum  = op_a + imm;

  always_comb begin
    next_pc = cond_true ? target_pc : seq_pc;
    if (is_jump) next_pc = jalr_src ? {jalr_sum[BUS_WIDTH-1:1], 1'b0} : target_pc;
  end

  // Jumps always redirect; conditional branches only when the IF guess was wrong.
  assign mispredict    = act & is_branch & (cond_true != pred_in);
  assign redirect_next = (act & is_jump) | mispredict;
  assign branch_taken  = act & (is_jump | (is_branch & cond_true));

  assign id_idx           = pc[IDX+1:2];
  assign if_idx           = if_pc[IDX+1:2];
  assign if_predict_taken = bht[if_idx][CTR_WIDTH-1];
  assign unused_bits      = ^{if_pc[BUS_WIDTH-1:IDX+2], if_pc[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= CTR_INIT;
    end else if (act && is_branch) begin
      if (cond_true && bht[id_idx] != CTR_MAX)
        bht[id_idx] <= bht[id_idx] + CTR_WIDTH'(1);
      else if (!cond_true && bht[id_idx] != CTR_MIN)
        bht[id_idx] <= bht[id_idx] - CTR_WIDTH'(1);
    end
  end

  // The squash flag tracks the redirect pulse but freezes while ID is stalled,
  // so a wrong-path instruction held by a stall is still ignored when released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      squash         <= 1'b0;
    end else begin
      redirect_valid <= redirect_next;
      if (redirect_next) redirect_pc <= next_pc;
      if (!stall) squash <= redirect_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (act && is_branch && branch_count != '1)
        branch_count <= branch_count + STAT_WIDTH'(1);
      if (mispredict && mispredict_count != '1)
        mispredict_count <= mispredict_count + STAT_WIDTH'(1);
    end
  end

endmodule
